mem_ctrl: RTL and testbench

- Sequences the single byte-wide RAM port and shares it between the instruction-fetch (IF) stage and the data-memory (MEM) stage.
- Assembles 32-bit instruction and data words over several byte cycles and serializes stores.
- Arbitrates between the two requesters, with fixed priority to MEM.
- Aborts in-flight fetches when the decode stage redirects the PC after a taken branch or jump.

---
 rtl/mem_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM sequencer shared by instruction fetch and data memory (optional MEM_CTRL_IFBUF_EN fetch buffer)
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic [31:0]           if_data_o,
    output logic                  if_done_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_len_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic [31:0]           mem_rdata_o,
    output logic                  mem_done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [7:0]            ram_dout_o,
    output logic                  ram_wr_o,
    input  logic [7:0]            ram_din_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [1:0]            len_q;
    logic [31:0]           wdata_q;
    logic                  owner_mem;
    logic [31:0]           asm_q;
    logic [31:0]           asm_next;
    logic [1:0]            cap_sel;
    logic [2:0]            nbytes;
    logic                  grant_mem;
    logic                  grant_if;
    logic                  read_complete;
    logic                  if_hit;
    logic [31:0]           ifbuf_word;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   len_bytes = 3'd1;
            2'b01:   len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

    assign nbytes    = len_bytes(len_q);
    assign grant_mem = (state == IDLE) && mem_req_i;
    assign grant_if  = (state == IDLE) && !mem_req_i && if_req_i && !if_flush_i;
    // A fetch whose last capture cycle coincides with a flush is not complete
    assign read_complete = (state == READ) && (cnt == nbytes) && (owner_mem || !if_flush_i);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: MEM has priority, flush only kills IF reads
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_mem) begin
                    state_next = mem_we_i ? WRITE : READ;
                end else if (grant_if) begin
                    state_next = if_hit ? DONE : READ;
                end
            end
            READ: begin
                if (!owner_mem && if_flush_i) begin
                    state_next = IDLE;
                end else if (cnt == nbytes) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                if (cnt == nbytes - 3'd1) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: RAM port driven from the latched request and byte counter
    always_comb begin
        ram_addr_o = '0;
        ram_dout_o = '0;
        ram_wr_o   = 1'b0;
        if_done_o  = 1'b0;
        mem_done_o = 1'b0;
        busy_o     = 1'b0;
        case (state)
            READ: begin
                busy_o     = 1'b1;
                ram_addr_o = base + ADDR_WIDTH'(cnt);
            end
            WRITE: begin
                busy_o     = 1'b1;
                ram_wr_o   = 1'b1;
                ram_addr_o = base + ADDR_WIDTH'(cnt);
                ram_dout_o = wdata_q[{cnt[1:0], 3'b000} +: 8];
            end
            DONE: begin
                busy_o     = 1'b1;
                if_done_o  = !owner_mem;
                mem_done_o = owner_mem;
            end
            default: ;
        endcase
    end

    // Read data arrives one cycle behind its address, so counter value c captures byte c-1
    always_comb begin
        asm_next = asm_q;
        cap_sel  = cnt[1:0] - 2'd1;
        if (state == READ && cnt != 3'd0) begin
            asm_next[{cap_sel, 3'b000} +: 8] = ram_din_i;
        end
    end

    // Request latching, byte counter, word assembly and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= 3'd0;
            base        <= '0;
            len_q       <= 2'b00;
            wdata_q     <= 32'd0;
            owner_mem   <= 1'b0;
            asm_q       <= 32'd0;
            if_data_o   <= 32'd0;
            mem_rdata_o <= 32'd0;
        end else begin
            asm_q <= asm_next;
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (grant_mem) begin
                        base      <= mem_addr_i;
                        len_q     <= mem_len_i;
                        wdata_q   <= mem_wdata_i;
                        owner_mem <= 1'b1;
                        asm_q     <= 32'd0;
                    end else if (grant_if) begin
                        base      <= if_addr_i;
                        len_q     <= 2'b11;
                        owner_mem <= 1'b0;
                        asm_q     <= 32'd0;
                        if (if_hit) begin
                            if_data_o <= ifbuf_word;
                        end
                    end
                end
                READ, WRITE: cnt <= cnt + 3'd1;
                default:     cnt <= 3'd0;
            endcase
            if (read_complete) begin
                if (owner_mem) begin
                    mem_rdata_o <= asm_next;
                end else begin
                    if_data_o <= asm_next;
                end
            end
        end
    end

`ifdef MEM_CTRL_IFBUF_EN
    logic                  ifbuf_valid;
    logic [ADDR_WIDTH-1:0] ifbuf_addr;
    logic [ADDR_WIDTH-1:0] dist_fwd;
    logic [ADDR_WIDTH-1:0] dist_bwd;
    logic                  store_hits_buf;

    // Modular distances catch overlap even when either range wraps past the top of memory
    assign dist_fwd       = mem_addr_i - ifbuf_addr;
    assign dist_bwd       = ifbuf_addr - mem_addr_i;
    assign store_hits_buf = mem_we_i && ((dist_fwd < ADDR_WIDTH'(4)) ||
                                         (dist_bwd < ADDR_WIDTH'(len_bytes(mem_len_i))));
    assign if_hit         = ifbuf_valid && (ifbuf_addr == if_addr_i);

    // Fetch buffer: refilled by every completed fetch, dropped by an overlapping store grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            ifbuf_valid <= 1'b0;
            ifbuf_addr  <= '0;
            ifbuf_word  <= 32'd0;
        end else if (grant_mem && store_hits_buf) begin
            ifbuf_valid <= 1'b0;
        end else if (read_complete && !owner_mem) begin
            ifbuf_valid <= 1'b1;
            ifbuf_addr  <= base;
            ifbuf_word  <= asm_next;
        end
    end
`else
    assign if_hit     = 1'b0;
    assign ifbuf_word = 32'd0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [31:0] ram_addr_o;
    logic [7:0]  ram_dout_o;
    logic        ram_wr_o;
    logic [7:0]  ram_din_i = 8'h00;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_if = 32'd0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
        .ram_din_i(ram_din_i), .busy_o(busy_o)
    );

    bit [7:0] ram_mem [bit [31:0]];
    bit [7:0] ref_mem [bit [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_byte(a);
    endfunction

    // Byte-wide synchronous RAM: read data one cycle after its address
    always @(posedge clk) begin
        if (ram_wr_o) ram_mem[ram_addr_o] = ram_dout_o;
        ram_din_i <= ram_rd(ram_addr_o);
    end

    function automatic int len_n(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] w;
        logic [31:0] ai;
        w = 32'd0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            w[8*i +: 8] = ref_mem.exists(ai) ? ref_mem[ai] : init_byte(ai);
        end
        return w;
    endfunction

    task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) ram_mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_txn(input bit m_en, input bit i_en, input bit we, input logic [1:0] len,
                           input logic [31:0] maddr, input logic [31:0] wdata,
                           input logic [31:0] iaddr, input int flush_at);
        int n, m_lat, i_lat, m_cnt, i_cnt, m_tick, i_tick;
        logic [31:0] m_exp, i_exp, m_got, i_got;
        n = len_n(len);
        m_exp = 32'd0;
        m_lat = 0;
        if (m_en) begin
            if (we) ref_write(maddr, n, wdata);
            else    m_exp = ref_read(maddr, n);
            m_lat = we ? n + 1 : n + 2;
        end
        i_exp = ref_read(iaddr, 4);
        i_lat = m_en ? m_lat + 7 : 6;
        mem_req_i = m_en; mem_we_i = we; mem_len_i = len; mem_addr_i = maddr; mem_wdata_i = wdata;
        if_req_i = i_en; if_addr_i = iaddr; if_flush_i = 1'b0;
        m_cnt = 0; i_cnt = 0; m_tick = -1; i_tick = -1; m_got = 32'd0; i_got = 32'd0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (mem_done_o) begin
                m_cnt++;
                if (m_cnt == 1) begin m_tick = t; m_got = mem_rdata_o; end
                mem_req_i = 1'b0;
            end
            if (if_done_o) begin
                i_cnt++;
                if (i_cnt == 1) begin i_tick = t; i_got = if_data_o; end
                if_req_i = 1'b0;
            end
            if (t == flush_at) begin
                if_flush_i = 1'b1;
                if_req_i   = 1'b0;
            end else begin
                if_flush_i = 1'b0;
            end
            // Requester inputs change after grant; the controller must use its latched copy
            if (mem_req_i) begin
                mem_addr_i = $urandom; mem_wdata_i = $urandom;
                mem_len_i = 2'($urandom_range(0, 3)); mem_we_i = 1'($urandom_range(0, 1));
            end
            if (if_req_i && t > (m_en ? m_lat + 1 : 0)) if_addr_i = $urandom;
        end
        if (m_en) begin
            chk("rnd_mem_done_count", m_cnt, 1);
            chk("rnd_mem_latency", m_tick, m_lat);
            if (!we) chk("rnd_mem_rdata", m_got, m_exp);
        end
        if (i_en) begin
            if (flush_at > 0) begin
                chk("rnd_flush_no_done", i_cnt, 0);
                chk("rnd_flush_data_hold", if_data_o, last_if);
            end else begin
                chk("rnd_if_done_count", i_cnt, 1);
                chk("rnd_if_latency", i_tick, i_lat);
                chk("rnd_if_data", i_got, i_exp);
                last_if = i_exp;
            end
        end
        chk("rnd_idle_after", busy_o, 0);
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_done;
        int got_t;
        logic [31:0] got_d;

        vecs[0]  = '{1'b1, 2'b11, 32'h2000, 32'h11223344, 32'h0,        5};
        vecs[1]  = '{1'b0, 2'b11, 32'h2000, 32'h0,        32'h11223344, 6};
        vecs[2]  = '{1'b0, 2'b00, 32'h2001, 32'h0,        32'h00000033, 3};
        vecs[3]  = '{1'b0, 2'b01, 32'h2002, 32'h0,        32'h00001122, 4};
        vecs[4]  = '{1'b0, 2'b10, 32'h2000, 32'h0,        32'h11223344, 6};
        vecs[5]  = '{1'b1, 2'b11, 32'h2004, 32'h0,        32'h0,        5};
        vecs[6]  = '{1'b1, 2'b01, 32'h2004, 32'hAAAA5566, 32'h0,        3};
        vecs[7]  = '{1'b0, 2'b11, 32'h2004, 32'h0,        32'h00005566, 6};
        vecs[8]  = '{1'b1, 2'b00, 32'h2007, 32'h123456FE, 32'h0,        2};
        vecs[9]  = '{1'b0, 2'b11, 32'h2004, 32'h0,        32'hFE005566, 6};
        vecs[10] = '{1'b1, 2'b10, 32'h2008, 32'hCAFEBABE, 32'h0,        5};
        vecs[11] = '{1'b0, 2'b11, 32'h2008, 32'h0,        32'hCAFEBABE, 6};
        vecs[12] = '{1'b0, 2'b00, 32'h0204, 32'h0,        32'h000000EF, 3};

        preload(32'h100, 32'h00100513);
        preload(32'h200, 32'h12345678);
        preload(32'h300, 32'h00000293);
        ram_mem[32'h1FFFE] = 8'h34;
        ram_mem[32'h1FFFF] = 8'h82;

        rst = 1'b0; if_req_i = 1'b0; if_addr_i = 32'd0; if_flush_i = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'd0; mem_wdata_i = 32'd0;

        // Reset state
        repeat (3) tick();
        chk("reset_ctrl_outputs", {ram_wr_o, busy_o, if_done_o, mem_done_o}, 4'b0000);
        chk("reset_ram_addr", ram_addr_o, 32'd0);
        chk("reset_ram_dout", ram_dout_o, 8'd0);
        chk("reset_data_regs", {if_data_o, mem_rdata_o}, 64'd0);
        rst = 1'b1;
        tick();
        chk("idle_busy", busy_o, 0);

        // Word fetch at 0x100
        if_addr_i = 32'h100; if_req_i = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t <= 4) chk($sformatf("fetch_addr_c%0d", t - 1), {ram_wr_o, ram_addr_o}, {1'b0, 32'h100 + 32'(t - 1)});
            if (t == 5) chk("fetch_no_early_done", if_done_o, 0);
            if (t == 6) begin
                chk("fetch_done", if_done_o, 1);
                chk("fetch_data", if_data_o, 32'h00100513);
                if_req_i = 1'b0;
            end
        end
        tick();

        // Simultaneous requests: MEM load word first, IF one cycle after mem_done
        if_addr_i = 32'h100; if_req_i = 1'b1;
        mem_addr_i = 32'h200; mem_len_i = 2'b11; mem_we_i = 1'b0; mem_req_i = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (t == 1) chk("arb_mem_first_addr", ram_addr_o, 32'h200);
            if (t == 6) begin
                chk("arb_mem_done", {mem_done_o, if_done_o}, 2'b10);
                chk("arb_mem_rdata", mem_rdata_o, 32'h12345678);
                mem_req_i = 1'b0;
            end
            if (t == 7) chk("arb_idle_gap", busy_o, 0);
            if (t == 8) chk("arb_if_addr", ram_addr_o, 32'h100);
            if (t == 13) begin
                chk("arb_if_done", if_done_o, 1);
                if_req_i = 1'b0;
            end
        end
        tick();

        // Store byte
        mem_addr_i = 32'h204; mem_wdata_i = 32'hDEADBEEF; mem_len_i = 2'b00; mem_we_i = 1'b1; mem_req_i = 1'b1;
        tick();
        chk("stb_write_cycle", {ram_wr_o, ram_addr_o, ram_dout_o}, {1'b1, 32'h204, 8'hEF});
        tick();
        chk("stb_done_cycle", {mem_done_o, ram_wr_o}, 2'b10);
        mem_req_i = 1'b0;
        tick();

        // Load half across 0x1FFFE/0x1FFFF
        mem_addr_i = 32'h1FFFE; mem_len_i = 2'b01; mem_we_i = 1'b0; mem_req_i = 1'b1;
        repeat (4) tick();
        chk("ldh_done", mem_done_o, 1);
        chk("ldh_data", mem_rdata_o, 32'h00008234);
        mem_req_i = 1'b0;
        tick();

        // Table-driven loads and stores
        for (int v = 0; v < 13; v++) begin
            mem_we_i = vecs[v].we; mem_len_i = vecs[v].len; mem_addr_i = vecs[v].addr;
            mem_wdata_i = vecs[v].wdata; mem_req_i = 1'b1;
            got_t = -1; got_d = 32'd0;
            for (int t = 1; t <= 10; t++) begin
                tick();
                if (mem_done_o && got_t < 0) begin
                    got_t = t; got_d = mem_rdata_o; mem_req_i = 1'b0;
                end
            end
            mem_req_i = 1'b0;
            chk($sformatf("vec%0d_latency", v), got_t, vecs[v].lat);
            if (!vecs[v].we) chk($sformatf("vec%0d_rdata", v), got_d, vecs[v].exp);
        end

        // Flush in READ cycle 2, new fetch at 0x300 one cycle later
        if_addr_i = 32'h100; if_req_i = 1'b1;
        cnt_done = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 3) begin if_flush_i = 1'b1; if_req_i = 1'b0; end
            if (t == 4) begin
                chk("flush_returns_idle", busy_o, 0);
                if_flush_i = 1'b0; if_addr_i = 32'h300; if_req_i = 1'b1;
            end
            if (t >= 3 && t <= 9 && if_done_o) cnt_done++;
            if (t == 10) begin
                chk("flush_no_done", cnt_done, 0);
                chk("refetch_done", if_done_o, 1);
                chk("refetch_data", if_data_o, 32'h00000293);
                if_req_i = 1'b0;
            end
        end
        tick();

        // Flush in the last capture cycle still suppresses done
        if_addr_i = 32'h100; if_req_i = 1'b1;
        repeat (5) tick();
        if_flush_i = 1'b1; if_req_i = 1'b0;
        tick();
        chk("late_flush_no_done", {if_done_o, busy_o}, 2'b00);
        chk("late_flush_data_hold", if_data_o, 32'h00000293);
        if_flush_i = 1'b0;
        tick();

        // Reset during a word store
        mem_addr_i = 32'h400; mem_wdata_i = 32'h01020304; mem_len_i = 2'b11; mem_we_i = 1'b1; mem_req_i = 1'b1;
        tick();
        chk("rst_store_writing", ram_wr_o, 1);
        rst = 1'b0;
        tick();
        chk("rst_mid_ctrl", {ram_wr_o, busy_o, if_done_o, mem_done_o}, 4'b0000);
        chk("rst_mid_bus", {ram_addr_o, ram_dout_o}, 40'd0);
        chk("rst_mid_data", {if_data_o, mem_rdata_o}, 64'd0);
        rst = 1'b1; mem_req_i = 1'b0;
        cnt_done = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (mem_done_o || busy_o) cnt_done++;
        end
        chk("rst_no_done_after", cnt_done, 0);
        last_if = 32'd0;

        // Randomized traffic against the reference memory
        for (int it = 0; it < 150; it++) begin
            int k;
            logic [31:0] ma, ia;
            k  = $urandom_range(0, 4);
            ma = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : 32'h3000 + $urandom_range(0, 23);
            ia = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : 32'h3000 + $urandom_range(0, 23);
            case (k)
                0: run_txn(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), ma, 32'd0, 32'd0, 0);
                1: run_txn(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)), ma, $urandom, 32'd0, 0);
                2: run_txn(1'b0, 1'b1, 1'b0, 2'b11, 32'd0, 32'd0, ia, 0);
                3: run_txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ma, $urandom, ia, 0);
                default: run_txn(1'b0, 1'b1, 1'b0, 2'b11, 32'd0, 32'd0, ia, $urandom_range(1, 5));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
